// File: rtl/dds_key_param_ctrl.sv
// Key-driven parameter controller for the dual-channel DDS datapath.
// Optional auto-repeat on Key[0]/Key[1]: define DDS_KEY_AUTOREPEAT_EN.
module dds_key_param_ctrl #(
    parameter int DEBOUNCE_CNT = 1_000_000,
    parameter int FWORD_BASE   = 85899,
    parameter int FREQ_STEPS   = 8,
    parameter int PWORD_W      = 12,
    parameter int PHASE_STEP   = 256,
    parameter int REPEAT_CNT   = 10_000_000
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic [3:0]         Key,
    output logic [31:0]        Fword1,
    output logic [31:0]        Fword2,
    output logic [PWORD_W-1:0] Pword1,
    output logic [PWORD_W-1:0] Pword2,
    output logic               Update,
    output logic               Busy
);

    localparam int CW = $clog2(DEBOUNCE_CNT + 1);
    localparam int IW = $clog2(FREQ_STEPS);
    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CNT - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(FREQ_STEPS - 1);
    localparam logic [31:0] FB = 32'(FWORD_BASE);
    localparam logic [PWORD_W-1:0] PSTEP = PWORD_W'(PHASE_STEP);

    if (DEBOUNCE_CNT < 2 || FREQ_STEPS < 2 || REPEAT_CNT < 2) begin : g_param_chk
        $error("dds_key_param_ctrl: counts must be at least 2");
    end

    typedef enum logic [1:0] {REL, PRESS_CHK, PRS, REL_CHK} db_t;
    typedef enum logic [1:0] {IDLE, CALC, COMMIT} st_t;

    logic [3:0]    sync1;
    logic [3:0]    ks;
    db_t           db_st  [4];
    db_t           db_nx  [4];
    logic [CW-1:0] db_cnt [4];
    logic [CW-1:0] db_cnx [4];
    logic [3:0]    db_ev;
    logic [3:0]    ev;

    st_t           st;
    st_t           st_nx;
    logic [3:0]    pend;
    logic [3:0]    pend_nx;
    logic [3:0]    grant;
    logic [3:0]    grant_nx;
    logic [3:0]    clr;

    logic [IW-1:0]      idx1;
    logic [IW-1:0]      idx2;
    logic [IW-1:0]      idx1_sh;
    logic [IW-1:0]      idx2_sh;
    logic [31:0]        f1_sh;
    logic [31:0]        f2_sh;
    logic [PWORD_W-1:0] p2_sh;

    // Synchroniser reads as released while in reset
    always_ff @(posedge Clk) begin
        if (Reset) begin
            sync1 <= '1;
            ks    <= '1;
        end else begin
            sync1 <= Key;
            ks    <= sync1;
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            db_nx[i]  = db_st[i];
            db_cnx[i] = db_cnt[i];
            db_ev[i]  = 1'b0;
            unique case (db_st[i])
                REL: begin
                    if (!ks[i]) begin
                        db_nx[i]  = PRESS_CHK;
                        db_cnx[i] = CW'(1);
                    end
                end
                PRESS_CHK: begin
                    if (ks[i]) begin
                        db_nx[i]  = REL;
                        db_cnx[i] = '0;
                    end else if (db_cnt[i] >= DB_LAST) begin
                        db_nx[i]  = PRS;
                        db_cnx[i] = '0;
                        db_ev[i]  = 1'b1;
                    end else begin
                        db_cnx[i] = db_cnt[i] + 1'b1;
                    end
                end
                PRS: begin
                    if (ks[i]) begin
                        db_nx[i]  = REL_CHK;
                        db_cnx[i] = CW'(1);
                    end
                end
                REL_CHK: begin
                    if (!ks[i]) begin
                        db_nx[i]  = PRS;
                        db_cnx[i] = '0;
                    end else if (db_cnt[i] >= DB_LAST) begin
                        db_nx[i]  = REL;
                        db_cnx[i] = '0;
                    end else begin
                        db_cnx[i] = db_cnt[i] + 1'b1;
                    end
                end
                default: begin
                    db_nx[i]  = REL;
                    db_cnx[i] = '0;
                end
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        for (int i = 0; i < 4; i++) begin
            if (Reset) begin
                db_st[i]  <= REL;
                db_cnt[i] <= '0;
            end else begin
                db_st[i]  <= db_nx[i];
                db_cnt[i] <= db_cnx[i];
            end
        end
    end

`ifdef DDS_KEY_AUTOREPEAT_EN
    localparam int RW = $clog2(REPEAT_CNT + 1);
    localparam logic [RW-1:0] RP_LAST = RW'(REPEAT_CNT - 1);

    logic [RW-1:0] rpt_cnt [2];
    logic [RW-1:0] rpt_nx  [2];
    logic [1:0]    rep_ev;

    // Period counter runs only while the key stays in PRS
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            rpt_nx[i] = '0;
            rep_ev[i] = 1'b0;
            if (db_st[i] == PRS && db_nx[i] == PRS) begin
                if (rpt_cnt[i] == RP_LAST) rep_ev[i] = 1'b1;
                else rpt_nx[i] = rpt_cnt[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge Clk) begin
        for (int i = 0; i < 2; i++) begin
            if (Reset) rpt_cnt[i] <= '0;
            else rpt_cnt[i] <= rpt_nx[i];
        end
    end

    assign ev = db_ev | {2'b00, rep_ev};
`else
    assign ev = db_ev;
`endif

    always_comb begin
        st_nx    = st;
        grant_nx = grant;
        clr      = '0;
        unique case (st)
            IDLE: begin
                if (|pend) begin
                    st_nx = CALC;
                    if (pend[3]) grant_nx = 4'b1000;
                    else if (pend[0]) grant_nx = 4'b0001;
                    else if (pend[1]) grant_nx = 4'b0010;
                    else grant_nx = 4'b0100;
                    clr = grant_nx;
                end
            end
            CALC: begin
                st_nx = COMMIT;
                if (grant[3]) clr = 4'b1111;
            end
            COMMIT: st_nx = IDLE;
            default: st_nx = IDLE;
        endcase
    end

    // A press landing in the same cycle as its clear keeps the bit set
    assign pend_nx = (pend & ~clr) | ev;

    always_comb begin
        idx1_sh = idx1;
        idx2_sh = idx2;
        f1_sh   = Fword1;
        f2_sh   = Fword2;
        p2_sh   = Pword2;
        unique case (1'b1)
            grant[3]: begin
                idx1_sh = '0;
                idx2_sh = '0;
                f1_sh   = FB;
                f2_sh   = FB;
                p2_sh   = '0;
            end
            grant[0]: begin
                idx1_sh = (idx1 == IDX_LAST) ? '0 : idx1 + 1'b1;
                f1_sh   = FB * (32'(idx1_sh) + 32'd1);
            end
            grant[1]: begin
                idx2_sh = (idx2 == IDX_LAST) ? '0 : idx2 + 1'b1;
                f2_sh   = FB * (32'(idx2_sh) + 32'd1);
            end
            grant[2]: p2_sh = Pword2 + PSTEP;
            default: ;
        endcase
    end

    // Shadows are written at the CALC->COMMIT edge so words and Update align
    always_ff @(posedge Clk) begin
        if (Reset) begin
            st     <= IDLE;
            pend   <= '0;
            grant  <= '0;
            idx1   <= '0;
            idx2   <= '0;
            Fword1 <= FB;
            Fword2 <= FB;
            Pword2 <= '0;
        end else begin
            st    <= st_nx;
            pend  <= pend_nx;
            grant <= grant_nx;
            if (st == CALC) begin
                idx1   <= idx1_sh;
                idx2   <= idx2_sh;
                Fword1 <= f1_sh;
                Fword2 <= f2_sh;
                Pword2 <= p2_sh;
            end
        end
    end

    assign Pword1 = '0;
    assign Update = (st == COMMIT) && !Reset;
    assign Busy   = (st != IDLE);

endmodule

// File: tb/tb_dds_key_param_ctrl.sv
// Self-checking bench for dds_key_param_ctrl against a behavioural model.
// Run with DEBOUNCE_CNT=100 and REPEAT_CNT=500 for short simulations.
module tb_dds_key_param_ctrl;

    localparam int DB = 100;
    localparam int RP = 500;
    localparam int FB = 85899;

    logic        clk = 1'b0;
    logic        Reset = 1'b1;
    logic [3:0]  Key = 4'hF;
    logic [31:0] Fword1;
    logic [31:0] Fword2;
    logic [11:0] Pword1;
    logic [11:0] Pword2;
    logic        Update;
    logic        Busy;

    dds_key_param_ctrl #(
        .DEBOUNCE_CNT(DB),
        .FWORD_BASE  (FB),
        .FREQ_STEPS  (8),
        .PWORD_W     (12),
        .PHASE_STEP  (256),
        .REPEAT_CNT  (RP)
    ) dut (
        .Clk   (clk),
        .Reset (Reset),
        .Key   (Key),
        .Fword1(Fword1),
        .Fword2(Fword2),
        .Pword1(Pword1),
        .Pword2(Pword2),
        .Update(Update),
        .Busy  (Busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int upd_cnt = 0;
    int last_upd = 0;
    logic [31:0] snap_f1[$];
    logic [31:0] snap_f2[$];
    always @(negedge clk) begin
        if (Update === 1'b1) begin
            upd_cnt++;
            last_upd = cyc;
            snap_f1.push_back(Fword1);
            snap_f2.push_back(Fword2);
        end
    end

    int passed = 0;
    int total = 0;
    int fall_cyc = 0;

    int m_idx1, m_idx2, m_pw2;

    function automatic int fw(input int i);
        return FB * (i + 1);
    endfunction

    function automatic void model_key(input int k);
        case (k)
            0: m_idx1 = (m_idx1 + 1) % 8;
            1: m_idx2 = (m_idx2 + 1) % 8;
            2: m_pw2 = (m_pw2 + 256) % 4096;
            default: begin
                m_idx1 = 0;
                m_idx2 = 0;
                m_pw2 = 0;
            end
        endcase
    endfunction

    task automatic do_reset();
        Reset = 1'b1;
        repeat (10) @(negedge clk);
        Reset = 1'b0;
        m_idx1 = 0;
        m_idx2 = 0;
        m_pw2 = 0;
        @(negedge clk);
    endtask

    task automatic press(input int k, input int hold);
        @(negedge clk);
        Key[k] = 1'b0;
        fall_cyc = cyc;
        repeat (hold) @(negedge clk);
        Key[k] = 1'b1;
        repeat (300) @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (Fword1 !== 32'(FB)) $display("FAIL reset_fword1 got %0d want %0d", Fword1, FB);
        else passed++;
        total++;
        if (Fword2 !== 32'(FB)) $display("FAIL reset_fword2 got %0d want %0d", Fword2, FB);
        else passed++;
        total++;
        if (Pword1 !== 12'd0) $display("FAIL reset_pword1 got %0d want 0", Pword1);
        else passed++;
        total++;
        if (Pword2 !== 12'd0) $display("FAIL reset_pword2 got %0d want 0", Pword2);
        else passed++;
        total++;
        if (Update !== 1'b0) $display("FAIL reset_update got %b want 0", Update);
        else passed++;
        total++;
        if (Busy !== 1'b0) $display("FAIL reset_busy got %b want 0", Busy);
        else passed++;
    endtask

    task automatic test_single();
        int n0;
        int lat;
        n0 = upd_cnt;
        press(0, 300);
        model_key(0);
        lat = last_upd - fall_cyc;
        total++;
        if (upd_cnt - n0 !== 1) $display("FAIL single_count got %0d want 1", upd_cnt - n0);
        else passed++;
        total++;
        if (lat < DB || lat > DB + 10)
            $display("FAIL single_latency got %0d want %0d..%0d", lat, DB, DB + 10);
        else passed++;
        total++;
        if (Fword1 !== 32'(fw(m_idx1))) $display("FAIL single_fword1 got %0d want %0d", Fword1, fw(m_idx1));
        else passed++;
        total++;
        if (Fword2 !== 32'(fw(m_idx2))) $display("FAIL single_fword2 got %0d want %0d", Fword2, fw(m_idx2));
        else passed++;
    endtask

    task automatic test_wrap();
        int n0;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            n0 = upd_cnt;
            press(0, DB + 50);
            model_key(0);
            total++;
            if (upd_cnt - n0 !== 1 || Fword1 !== 32'(fw(m_idx1)))
                $display("FAIL wrap_%0d got %0d (%0d upd) want %0d", i, Fword1, upd_cnt - n0, fw(m_idx1));
            else passed++;
        end
        total++;
        if (Fword1 !== 32'(FB)) $display("FAIL wrap_final got %0d want %0d", Fword1, FB);
        else passed++;
    endtask

    task automatic test_glitch();
        int n0;
        n0 = upd_cnt;
        press(0, DB / 2);
        total++;
        if (upd_cnt - n0 !== 0) $display("FAIL glitch_count got %0d want 0", upd_cnt - n0);
        else passed++;
        n0 = upd_cnt;
        for (int i = 0; i < 12; i++) begin
            Key[0] = ~Key[0];
            repeat (20) @(negedge clk);
        end
        Key[0] = 1'b1;
        repeat (300) @(negedge clk);
        total++;
        if (upd_cnt - n0 !== 0 || Fword1 !== 32'(fw(m_idx1)))
            $display("FAIL bounce got %0d upd fword1 %0d want 0 upd %0d", upd_cnt - n0, Fword1, fw(m_idx1));
        else passed++;
    endtask

    task automatic test_phase();
        int n0;
        do_reset();
        n0 = upd_cnt;
        for (int i = 0; i < 17; i++) begin
            press(2, DB + 20);
            model_key(2);
        end
        total++;
        if (upd_cnt - n0 !== 17) $display("FAIL phase_count got %0d want 17", upd_cnt - n0);
        else passed++;
        total++;
        if (Pword2 !== 12'(m_pw2)) $display("FAIL phase_pword2 got %0d want %0d", Pword2, m_pw2);
        else passed++;
        total++;
        if (Pword1 !== 12'd0) $display("FAIL phase_pword1 got %0d want 0", Pword1);
        else passed++;
    endtask

    task automatic test_back_to_back();
        int n0;
        do_reset();
        snap_f1.delete();
        snap_f2.delete();
        n0 = upd_cnt;
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            Key[1:0] = ~Key[1:0];
            repeat (20) @(negedge clk);
        end
        Key[1:0] = 2'b00;
        repeat (DB + 100) @(negedge clk);
        Key[1:0] = 2'b11;
        repeat (300) @(negedge clk);
        total++;
        if (upd_cnt - n0 !== 2) $display("FAIL b2b_count got %0d want 2", upd_cnt - n0);
        else passed++;
        total++;
        if (snap_f1.size() < 1 || snap_f1[0] !== 32'(fw(1)) || snap_f2[0] !== 32'(FB))
            $display("FAIL b2b_order got f1=%0d f2=%0d want f1=%0d f2=%0d",
                     snap_f1.size() ? snap_f1[0] : 0, snap_f2.size() ? snap_f2[0] : 0, fw(1), FB);
        else passed++;
        model_key(0);
        model_key(1);
        total++;
        if (Fword1 !== 32'(fw(m_idx1)) || Fword2 !== 32'(fw(m_idx2)))
            $display("FAIL b2b_final got %0d/%0d want %0d/%0d", Fword1, Fword2, fw(m_idx1), fw(m_idx2));
        else passed++;
    endtask

    task automatic test_random();
        int n0;
        int k;
        for (int i = 0; i < 12; i++) begin
            k = $urandom_range(0, 2);
            n0 = upd_cnt;
            press(k, $urandom_range(DB + 20, 250));
            model_key(k);
            total++;
            if (upd_cnt - n0 !== 1 || Fword1 !== 32'(fw(m_idx1)) ||
                Fword2 !== 32'(fw(m_idx2)) || Pword2 !== 12'(m_pw2))
                $display("FAIL rand_%0d key%0d got %0d/%0d/%0d (%0d upd) want %0d/%0d/%0d",
                         i, k, Fword1, Fword2, Pword2, upd_cnt - n0,
                         fw(m_idx1), fw(m_idx2), m_pw2);
            else passed++;
        end
    endtask

    task automatic test_restore();
        int n0;
        press(0, DB + 30);
        model_key(0);
        press(2, DB + 30);
        model_key(2);
        n0 = upd_cnt;
        press(3, DB + 30);
        model_key(3);
        total++;
        if (upd_cnt - n0 !== 1) $display("FAIL restore_count got %0d want 1", upd_cnt - n0);
        else passed++;
        total++;
        if (Fword1 !== 32'(FB) || Fword2 !== 32'(FB) || Pword2 !== 12'd0)
            $display("FAIL restore_words got %0d/%0d/%0d want %0d/%0d/0", Fword1, Fword2, Pword2, FB, FB);
        else passed++;
        // Key[3] together with Key[0]: restore wins and drops the other request
        press(0, DB + 30);
        model_key(0);
        n0 = upd_cnt;
        @(negedge clk);
        Key = 4'b0110;
        repeat (DB + 50) @(negedge clk);
        Key = 4'hF;
        repeat (300) @(negedge clk);
        model_key(3);
        total++;
        if (upd_cnt - n0 !== 1 || Fword1 !== 32'(FB))
            $display("FAIL restore_prio got %0d upd fword1 %0d want 1 upd %0d", upd_cnt - n0, Fword1, FB);
        else passed++;
    endtask

    task automatic test_reset_busy();
        int n0;
        int waited;
        press(0, DB + 30);
        model_key(0);
        n0 = upd_cnt;
        @(negedge clk);
        Key[1] = 1'b0;
        waited = 0;
        while (Busy !== 1'b1 && waited < 400) begin
            @(negedge clk);
            waited++;
        end
        total++;
        if (Busy !== 1'b1) $display("FAIL rbusy_timeout got busy %b want 1", Busy);
        else passed++;
        Reset = 1'b1;
        Key[1] = 1'b1;
        @(negedge clk);
        Reset = 1'b0;
        model_key(3);
        total++;
        if (Fword1 !== 32'(FB) || Busy !== 1'b0)
            $display("FAIL rbusy_defaults got fword1 %0d busy %b want %0d 0", Fword1, Busy, FB);
        else passed++;
        repeat (300) @(negedge clk);
        total++;
        if (upd_cnt - n0 !== 0 || Fword2 !== 32'(FB))
            $display("FAIL rbusy_noupd got %0d upd fword2 %0d want 0 upd %0d", upd_cnt - n0, Fword2, FB);
        else passed++;
    endtask

`ifdef DDS_KEY_AUTOREPEAT_EN
    task automatic test_autorepeat();
        int n0;
        do_reset();
        n0 = upd_cnt;
        press(0, DB + 2 + 1300);
        model_key(0);
        model_key(0);
        model_key(0);
        total++;
        if (upd_cnt - n0 !== 3) $display("FAIL repeat_count got %0d want 3", upd_cnt - n0);
        else passed++;
        total++;
        if (Fword1 !== 32'(fw(m_idx1))) $display("FAIL repeat_fword1 got %0d want %0d", Fword1, fw(m_idx1));
        else passed++;
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_wrap();
        test_glitch();
        test_phase();
        test_back_to_back();
        test_random();
        test_restore();
        test_reset_busy();
`ifdef DDS_KEY_AUTOREPEAT_EN
        test_autorepeat();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/dds_key_param_ctrl.md
Name: dds_key_param_ctrl

Overview:
- Front-panel controller for the dual-channel DDS/AD9767 datapath.
- Debounces four push keys and turns each press into a parameter change: channel 1 frequency step, channel 2 frequency step, channel 2 phase step, or restore defaults.
- A small transaction FSM serialises the changes and commits each one with a single-cycle update strobe.
- The frequency and phase words it produces feed the DDS phase accumulators directly.

Parameters:
- DEBOUNCE_CNT, 1_000_000, stable-level cycles needed to accept a press or a release (20 ms at 50 MHz).
- FWORD_BASE, 85899, frequency word for index 0. This is 1 kHz at 50 MHz with a 32-bit accumulator.
- FREQ_STEPS, 8, number of frequency indices (0..FREQ_STEPS-1).
- PWORD_W, 12, phase word width.
- PHASE_STEP, 256, phase increment per Key[2] press.
- REPEAT_CNT, 10_000_000, auto-repeat period. Used only with the optional feature.

Ports:
- Clk  in  1  system clock, 50 MHz.
- Reset  in  1  synchronous, active-high reset.
- Key  in  4  raw key inputs, active-low (0 = pressed), asynchronous.
- Fword1  out  32  channel 1 frequency word.
- Fword2  out  32  channel 2 frequency word.
- Pword1  out  PWORD_W  channel 1 phase offset.
- Pword2  out  PWORD_W  channel 2 phase offset.
- Update  out  1  one-cycle strobe, high in the cycle the words change.
- Busy  out  1  high while the FSM is outside IDLE.

Behaviour:
- Clocking and reset:
  - Single clock domain. Reset is synchronous and active-high.
  - Reset values: Fword1 = Fword2 = FWORD_BASE, Pword1 = Pword2 = 0, Update = 0, Busy = 0.
  - Reset also clears the frequency indices, phase index, pending bits and debounce counters.
- Input synchronisation: each Key bit passes through a 2-FF synchroniser. The synchronised value is treated as released (1) during reset.
- Debounce, per key, with states REL → PRESS_CHK → PRS → REL_CHK:
  - The counter counts consecutive cycles at the opposite level and clears on any bounce.
  - REL→PRS: the count reaches DEBOUNCE_CNT. This emits a one-cycle press event.
  - PRS→REL: the count reaches DEBOUNCE_CNT. No event is emitted.
  - One event per press. A held key produces no further events, except with the optional feature.
- Pending register (4 bits):
  - A press event sets its bit.
  - The FSM clears the bit in the cycle it grants it.
  - If set and grant coincide for the same bit, the bit stays set.
- FSM, with states IDLE → CALC → COMMIT → IDLE:
  - IDLE: if any pending bit is set, grant the highest-priority bit and go to CALC. Priority is Key[3] > Key[0] > Key[1] > Key[2].
  - CALC: compute the shadow values from the granted key.
  - COMMIT: copy the shadows to the outputs, pulse Update, return to IDLE.
  - Busy = (state != IDLE).
  - Latency: a press event in cycle N sets its pending bit in N+1. If the FSM is idle it grants in N+1 and is in CALC in N+2. The outputs change and Update = 1 in N+3.
  - Back-to-back transactions are separated by at least one IDLE cycle.
- Actions:
  - Key[0]: idx1 = (idx1 == FREQ_STEPS-1) ? 0 : idx1+1; Fword1 = FWORD_BASE*(idx1+1), truncated to 32 bits.
  - Key[1]: the same rule for idx2 and Fword2.
  - Key[2]: Pword2 = (Pword2 + PHASE_STEP) mod 2^PWORD_W.
  - Key[3]: restore all reset values (indices, words) and clear every other pending bit. Update still pulses.
- Pword1 is not key-controlled. It stays 0.
- Reset asserted mid-transaction forces IDLE and the reset values on the next edge. No Update pulse is produced.

Optional Feature:
- Macro: DDS_KEY_AUTOREPEAT_EN.
- Defined:
  - Key[0] and Key[1] held in PRS emit an additional press event every REPEAT_CNT cycles.
  - The period counter starts at PRS entry and clears on leaving PRS.
  - Key[2] and Key[3] never repeat.
- Undefined:
  - Exactly one event per debounced press.
  - No repeat counter logic is synthesised.

Test Plan (DEBOUNCE_CNT=100, REPEAT_CNT=500 in the bench):
- Reset held 10 cycles, then released → Fword1 = Fword2 = 85899, Pword1 = Pword2 = 0, Update = 0, Busy = 0.
- Key[0] low 300 cycles, then high 300 cycles → exactly one Update pulse, Fword1 = 171798, Fword2 = 85899. Update lands 3 cycles after the internal press event.
- Key[0] pressed 8 times → Fword1 sequence 171798, 257697, … 687192, then 85899 (wrap). Glitch tests:
  - A 50-cycle low glitch → no Update.
  - A bouncing low (toggle every 20 cycles) → no Update.
- Key[2] pressed 17 times → Pword2 = 256 (wrap modulo 4096). Pword1 stays 0.
- Key[0] and Key[1] released from bounce so both debounce in the same cycle → two Update pulses.
  - Key[0] is served first.
  - The final values are Fword1 = 171798 and Fword2 = 171798.
- Mixed sequence:
  - Key[3] pressed after several changes → all words return to reset values with one Update.
  - Reset asserted while Busy = 1 → no Update, defaults next cycle.
  - With DDS_KEY_AUTOREPEAT_EN, Key[0] held 1300 cycles past debounce → 3 Update pulses (1 + 2 repeats).
